decrypt: RTL and testbench

- LWE decryption engine; the receive-side counterpart of `encrypt`.
- Consumes one ciphertext vector as a stream of LITTLE_N "a" elements, each paired with its secret-key element, followed by one "b" element.
- Computes m = round((b - <a,s>) * p / q) mod p and presents the recovered plaintext on a valid/ready output.
- Sits between the ciphertext source (memory/bus) and the plaintext consumer.

---
 rtl/decrypt.sv | 142 ++++++++++++++
 tb/tb_decrypt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt.sv
// decrypt: LWE decryption engine.
// Streams LITTLE_N (a_i, s_i) pairs, accumulates <a,s> mod q, then takes the
// final "b" element and recovers m = round((b - <a,s>) * p / q) mod p.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   go                  - start pulse, sampled only in IDLE
//   in_valid/in_ready   - input element handshake
//   in_last             - marks the "b" element
//   ciphertext          - a_i, or b on the last beat
//   secretkey           - s_i paired with a_i (ignored on the b beat)
//   out_valid/out_ready - plaintext handshake
//   plaintext           - recovered message, held stable while out_valid
//   busy                - high whenever not IDLE
//   err                 - one-cycle pulse on a framing error
module decrypt #(
  parameter int PLAINTEXT_WIDTH    = 8,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int LITTLE_N           = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext,
  input  logic [CIPHERTEXT_WIDTH-1:0] secretkey,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  output logic                        busy,
  output logic                        err
);

  localparam int W  = CIPHERTEXT_WIDTH;
  localparam int P  = PLAINTEXT_WIDTH;
  localparam int CW = (LITTLE_N > 1) ? $clog2(LITTLE_N) : 1;
  // Rounding offset: half of one plaintext step expressed in Z_q units.
  localparam logic [W:0] HALF = {{W{1'b0}}, 1'b1} << (W - P - 1);

  if (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH)) begin : g_bad_modulus
    $error("decrypt: CIPHERTEXT_MODULUS must equal 2**CIPHERTEXT_WIDTH");
  end
  if (PLAINTEXT_WIDTH > CIPHERTEXT_WIDTH - 1) begin : g_bad_width
    $error("decrypt: PLAINTEXT_WIDTH must be <= CIPHERTEXT_WIDTH-1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P-1:0]  pt_q, pt_d;
  logic          err_q, err_d;

  logic [2*W-1:0] prod;
  logic [W-1:0]   diff;
  logic [W:0]     rounded;
  logic           xfer;
  logic           last_a;

  assign in_ready  = (state_q == ACCUM) || (state_q == FINAL);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign plaintext = pt_q;
  assign err       = err_q;

  assign xfer    = in_valid && in_ready;
  assign last_a  = (cnt_q == CW'(LITTLE_N - 1));
  assign prod    = ciphertext * secretkey;
  assign diff    = ciphertext - acc_q;
  assign rounded = {1'b0, diff} + HALF;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (in_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            // Sum over the full product; truncating to W bits is the mod q.
            acc_d = W'(acc_q + prod);
            cnt_d = cnt_q + CW'(1);
            if (last_a) state_d = FINAL;
          end
        end
      end
      FINAL: begin
        if (xfer) begin
          if (in_last) begin
            // Bits above P after the shift are dropped: wrap at p.
            pt_d    = P'(rounded >> (W - P));
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      pt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_decrypt.sv
// tb_decrypt: directed self-checking bench for decrypt.
// Expected plaintexts are pushed to a scoreboard queue when a ciphertext is
// sent and popped when the DUT presents its output.
module tb_decrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  logic [9:0] ciphertext = '0;
  logic [9:0] secretkey = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] plaintext;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  decrypt #(
    .PLAINTEXT_WIDTH   (8),
    .CIPHERTEXT_WIDTH  (10),
    .CIPHERTEXT_MODULUS(1024),
    .LITTLE_N          (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .ciphertext(ciphertext),
    .secretkey (secretkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: round((b - acc) * p / q) mod p with q=1024, p=256.
  function automatic logic [7:0] model(input int unsigned acc, input int unsigned b);
    int unsigned d;
    d = (b + 1024 - (acc % 1024)) % 1024;
    return 8'(((d + 2) / 4) % 256);
  endfunction

  task automatic start();
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Drives one beat and holds it until accepted; returns at posedge+1
  // just after the transfer edge.
  task automatic send(input logic [9:0] ct, input logic [9:0] sk, input logic last,
                      input int unsigned gap);
    int cycles;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid   = 1'b1;
    ciphertext = ct;
    secretkey  = sk;
    in_last    = last;
    cycles = 0;
    @(negedge clk);
    while (!in_ready && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full ciphertext with a=[10,20], s=[3,5] (acc=130).
  task automatic run_vec(input logic [9:0] b, input int unsigned maxgap);
    start();
    send(10'd10, 10'd3, 1'b0, $urandom_range(0, maxgap));
    send(10'd20, 10'd5, 1'b0, $urandom_range(0, maxgap));
    sb.push_back(model(130, b));
    send(b, 10'd0, 1'b1, $urandom_range(0, maxgap));
    check("out_valid_latency", 32'(out_valid), 1);
  endtask

  task automatic receive(input string tag, input int unsigned stall);
    logic [7:0] exp;
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 0, 1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    for (int unsigned i = 0; i < stall; i++) begin
      go = 1'b1;
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(out_valid), 1);
      check({tag, "_stall_data"}, 32'(plaintext), 32'(exp));
      check({tag, "_stall_in_ready"}, 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    go = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_plaintext"}, 32'(plaintext), 32'(exp));
    check({tag, "_busy_before"}, 32'(busy), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_plaintext", 32'(plaintext), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    #20;
    rst_n = 1'b1;

    // in_valid in IDLE is ignored
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    // Basic and rounding boundaries
    run_vec(10'd151, 0); receive("basic_151", 0);
    run_vec(10'd148, 0); receive("round_148", 0);
    run_vec(10'd152, 0); receive("round_half_152", 0);
    run_vec(10'd129, 0); receive("diff1023_129", 0);
    // Wrap-around
    run_vec(10'd127, 0); receive("wrap_127", 0);
    run_vec(10'd128, 0); receive("wrap_128", 0);
    check("expected_255", 32'(model(130, 127)), 255);

    // Random input gaps
    for (int unsigned k = 0; k < 6; k++) begin
      run_vec(10'($urandom_range(0, 1023)), 3);
      receive("gaps", 0);
    end

    // Output backpressure with go asserted in DONE
    run_vec(10'd151, 0); receive("backpressure", 5);
    repeat (2) @(posedge clk);
    #1;
    check("go_in_done_ignored", 32'(busy), 0);

    // Early last on first a beat
    start();
    send(10'd10, 10'd3, 1'b1, 0);
    check("early_err", 32'(err), 1);
    check("early_idle", 32'(busy), 0);
    check("early_no_out", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("early_err_pulse", 32'(err), 0);

    // Missing last on b beat
    start();
    send(10'd10, 10'd3, 1'b0, 0);
    send(10'd20, 10'd5, 1'b0, 0);
    check("final_no_err_yet", 32'(err), 0);
    send(10'd151, 10'd0, 1'b0, 0);
    check("missing_err", 32'(err), 1);
    check("missing_idle", 32'(busy), 0);
    check("missing_no_out", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("missing_err_pulse", 32'(err), 0);

    // Reset mid-ACCUM, then a clean run
    start();
    send(10'd10, 10'd3, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(10'd151, 1); receive("after_reset", 0);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
